// File: rtl/i2s_rx_deserializer.sv
// Philips-I2S receiver: oversamples SCLK/LRCK/SD in the system clock domain and emits one
// left/right DATA_W-bit sample pair per LRCK period, with a framing-error strobe for bad slots.
module i2s_rx_deserializer #(
    parameter int DATA_W      = 24,
    parameter int SLOT_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_100mhz,
    input  logic              reset_btn,
    input  logic              sclk_in,
    input  logic              lrck_in,
    input  logic              sd_in,
    output logic [DATA_W-1:0] l_data,
    output logic [DATA_W-1:0] r_data,
    output logic              sample_valid,
    output logic              frame_err,
    output logic              locked,
    output logic [1:0]        dbg_state_o
);

    localparam int CNT_W = $clog2(SLOT_W + 2);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DW  = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_W);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(SLOT_W + 1);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        LEFT      = 2'd1,
        RIGHT     = 2'd2
    } state_t;

    state_t                  state_q;
    logic [SYNC_STAGES-1:0]  sclk_sync_q, lrck_sync_q, sd_sync_q;
    logic                    sclk_hist_q, lrck_hist_q;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]       shift_q, shift_d;
    logic [DATA_W-1:0]       left_hold_q, l_data_q, r_data_q;
    logic                    left_ok_q, valid_q, err_q, locked_q;

    logic sclk_s, lrck_s, sd_s;
    logic sclk_rise, lrck_rise, lrck_fall, lrck_edge, slot_good;

    // Equal synchronizer depth on all three pins keeps sd_s aligned with the sclk_s edge it belongs to.
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign lrck_s    = lrck_sync_q[SYNC_STAGES-1];
    assign sd_s      = sd_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign lrck_rise = lrck_s & ~lrck_hist_q;
    assign lrck_fall = ~lrck_s & lrck_hist_q;
    assign lrck_edge = lrck_rise | lrck_fall;
    assign slot_good = (bit_cnt_q >= CNT_MIN) && (bit_cnt_q <= CNT_MAX);

    // Bit counter 0 is the I2S delay bit; an SCLK rise coinciding with an LRCK edge is that delay bit.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        if (lrck_edge) begin
            bit_cnt_d = sclk_rise ? CNT_ONE : '0;
            shift_d   = '0;
        end else if (sclk_rise) begin
            if (bit_cnt_q >= CNT_ONE && bit_cnt_q <= CNT_DW) begin
                shift_d = {shift_q[DATA_W-2:0], sd_s};
            end
            if (bit_cnt_q != CNT_SAT) begin
                bit_cnt_d = bit_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_100mhz or posedge reset_btn) begin
        if (reset_btn) begin
            sclk_sync_q <= '0;
            lrck_sync_q <= '0;
            sd_sync_q   <= '0;
            sclk_hist_q <= 1'b0;
            lrck_hist_q <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            left_hold_q <= '0;
            left_ok_q   <= 1'b0;
            l_data_q    <= '0;
            r_data_q    <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            locked_q    <= 1'b0;
            state_q     <= WAIT_SYNC;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
            lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], lrck_in};
            sd_sync_q   <= {sd_sync_q[SYNC_STAGES-2:0], sd_in};
            sclk_hist_q <= sclk_s;
            lrck_hist_q <= lrck_s;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                WAIT_SYNC: begin
                    if (lrck_fall) begin
                        state_q  <= LEFT;
                        locked_q <= 1'b1;
                    end
                end
                LEFT: begin
                    if (lrck_rise) begin
                        state_q <= RIGHT;
                        if (slot_good) begin
                            left_hold_q <= shift_q;
                            left_ok_q   <= 1'b1;
                        end else begin
                            left_ok_q <= 1'b0;
                            err_q     <= 1'b1;
                        end
                    end
                end
                RIGHT: begin
                    if (lrck_fall) begin
                        state_q <= LEFT;
                        if (!slot_good) begin
                            err_q <= 1'b1;
                        end else if (left_ok_q) begin
                            l_data_q <= left_hold_q;
                            r_data_q <= shift_q;
                            valid_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= WAIT_SYNC;
            endcase
        end
    end

    // sample_valid is a one-cycle strobe with no backpressure: the consumer must take l_data/r_data
    // in the strobe cycle or later, as both hold until the next strobe.
    assign l_data       = l_data_q;
    assign r_data       = r_data_q;
    assign sample_valid = valid_q;
    assign frame_err    = err_q;
    assign locked       = locked_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed bench for i2s_rx_deserializer: bit-level I2S driver, pair scoreboard, vector table
// for slot-length boundaries, and hand-written reset/lock sequences.
`timescale 1ns/1ps
module tb_i2s_rx_deserializer;

    logic        clk_100mhz = 1'b0;
    logic        reset_btn;
    logic        sclk_in, lrck_in, sd_in;
    logic [23:0] l_data, r_data;
    logic        sample_valid, frame_err, locked;
    logic [1:0]  dbg_state_o;

    int checks   = 0;
    int failures = 0;
    int half_ns  = 40;
    int cyc      = 0;
    int valid_seen = 0;
    int err_seen   = 0;
    int prev_cyc   = 0;
    bit have_prev  = 1'b0;
    bit spacing_on = 1'b0;
    logic [47:0] exp_q[$];

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        int          nl;
        int          nr;
        int          exp_valid;
        int          exp_err;
    } vec_t;

    vec_t vecs[8];

    i2s_rx_deserializer dut (
        .clk_100mhz  (clk_100mhz),
        .reset_btn   (reset_btn),
        .sclk_in     (sclk_in),
        .lrck_in     (lrck_in),
        .sd_in       (sd_in),
        .l_data      (l_data),
        .r_data      (r_data),
        .sample_valid(sample_valid),
        .frame_err   (frame_err),
        .locked      (locked),
        .dbg_state_o (dbg_state_o)
    );

    // clock / watchdog
    always #5 clk_100mhz = ~clk_100mhz;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard / monitor: sampled on the falling clock edge
    always @(negedge clk_100mhz) begin
        cyc++;
        if (frame_err) err_seen++;
        if (sample_valid) begin
            valid_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid: got l=%0h r=%0h expected no valid", l_data, r_data);
            end else begin
                logic [47:0] e;
                e = exp_q.pop_front();
                if ({l_data, r_data} !== e) begin
                    failures++;
                    $display("FAIL pair_data: got l=%0h r=%0h expected l=%0h r=%0h",
                             l_data, r_data, e[47:24], e[23:0]);
                end
            end
            if (spacing_on) begin
                if (have_prev) begin
                    checks++;
                    if (cyc - prev_cyc != 512) begin
                        failures++;
                        $display("FAIL valid_spacing: got %0d expected 512 clks", cyc - prev_cyc);
                    end
                end
                have_prev = 1'b1;
                prev_cyc  = cyc;
            end
        end
    end

    // driver: one slot of n SCLK periods; bit 0 is the delay bit (driven opposite to the MSB), pad bits are 1
    task automatic send_slot(input logic lv, input logic [23:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            sclk_in = 1'b0;
            lrck_in = lv;
            if (i == 0)       sd_in = ~data[23];
            else if (i <= 24) sd_in = data[24 - i];
            else              sd_in = 1'b1;
            #(half_ns);
            sclk_in = 1'b1;
            #(half_ns);
        end
    endtask

    // LRCK falling edge that closes the right slot, then idle long enough for the strobes to appear
    task automatic close_frame();
        sclk_in = 1'b0;
        lrck_in = 1'b0;
        sd_in   = 1'b0;
        repeat (24) @(negedge clk_100mhz);
    endtask

    task automatic send_pair(input logic [23:0] l, input logic [23:0] r);
        send_slot(1'b0, l, 32);
        send_slot(1'b1, r, 32);
    endtask

    initial begin
        int v0, e0;
        vecs[0] = '{24'hA5A5A5, 24'h5A5A5A, 32, 32, 1, 0};
        vecs[1] = '{24'hFFFFFF, 24'h000000, 25, 25, 1, 0};
        vecs[2] = '{24'h123456, 24'h654321, 32, 24, 0, 1};
        vecs[3] = '{24'hABCDEF, 24'h123456, 16, 32, 0, 1};
        vecs[4] = '{24'h0F0F0F, 24'hF0F0F0, 32, 40, 0, 1};
        vecs[5] = '{24'h111111, 24'h222222, 33, 32, 0, 1};
        vecs[6] = '{24'h7FFFFF, 24'h800000, 32, 32, 1, 0};
        vecs[7] = '{24'h000001, 24'hFFFFFE, 25, 32, 1, 0};

        reset_btn = 1'b1;
        sclk_in   = 1'b0;
        lrck_in   = 1'b1;
        sd_in     = 1'b0;
        repeat (5) @(negedge clk_100mhz);
        check("rst_l_data", 48'(l_data), 48'h0);
        check("rst_r_data", 48'(r_data), 48'h0);
        check("rst_flags", 48'({sample_valid, frame_err, locked}), 48'h0);
        check("rst_state", 48'(dbg_state_o), 48'h0);
        reset_btn = 1'b0;

        // single pair at 3.125 MHz SCLK after a long idle
        half_ns = 160;
        repeat (2000) @(negedge clk_100mhz);
        check("t1_unlocked", 48'(locked), 48'h0);
        v0 = valid_seen; e0 = err_seen;
        close_frame();
        check("t1_locked", 48'(locked), 48'h1);
        check("t1_state_left", 48'(dbg_state_o), 48'h1);
        exp_q.push_back({24'h7FF0FF, 24'h7FF0FF});
        send_pair(24'h7FF0FF, 24'h7FF0FF);
        close_frame();
        check("t1_valids", 48'(valid_seen - v0), 48'h1);
        check("t1_errs", 48'(err_seen - e0), 48'h0);
        check("t1_l_data", 48'(l_data), 48'h7FF0FF);
        check("t1_r_data", 48'(r_data), 48'h7FF0FF);

        // continuous stream: MSB alignment and strobe spacing
        half_ns = 40;
        v0 = valid_seen; e0 = err_seen;
        have_prev  = 1'b0;
        spacing_on = 1'b1;
        for (int p = 0; p < 61; p++) begin
            logic [23:0] l, r;
            l = (p == 0) ? 24'h800001 : 24'h000000;
            r = (p == 0) ? 24'h000001 : 24'h000000;
            exp_q.push_back({l, r});
            send_pair(l, r);
        end
        close_frame();
        spacing_on = 1'b0;
        check("t2_valids", 48'(valid_seen - v0), 48'd61);
        check("t2_errs", 48'(err_seen - e0), 48'h0);
        check("t2_l_data", 48'(l_data), 48'h0);
        check("t2_r_data", 48'(r_data), 48'h0);

        // slot-length table
        begin
            logic [23:0] last_l, last_r;
            last_l = 24'h0;
            last_r = 24'h0;
            for (int i = 0; i < 8; i++) begin
                v0 = valid_seen; e0 = err_seen;
                if (vecs[i].exp_valid != 0) begin
                    exp_q.push_back({vecs[i].l, vecs[i].r});
                    last_l = vecs[i].l;
                    last_r = vecs[i].r;
                end
                send_slot(1'b0, vecs[i].l, vecs[i].nl);
                send_slot(1'b1, vecs[i].r, vecs[i].nr);
                close_frame();
                check($sformatf("vec%0d_valids", i), 48'(valid_seen - v0), 48'(vecs[i].exp_valid));
                check($sformatf("vec%0d_errs", i), 48'(err_seen - e0), 48'(vecs[i].exp_err));
                check($sformatf("vec%0d_l_data", i), 48'(l_data), 48'(last_l));
                check($sformatf("vec%0d_r_data", i), 48'(r_data), 48'(last_r));
            end
        end

        // reset held through a left slot, released mid right slot
        reset_btn = 1'b1;
        #1;
        check("t3_rst_locked", 48'(locked), 48'h0);
        check("t3_rst_l_data", 48'(l_data), 48'h0);
        @(negedge clk_100mhz);
        v0 = valid_seen; e0 = err_seen;
        send_slot(1'b0, 24'hDEAD00, 32);
        fork
            send_slot(1'b1, 24'hBEEF00, 32);
            begin
                #(16 * 2 * half_ns);
                reset_btn = 1'b0;
            end
        join
        check("t3_unlocked", 48'(locked), 48'h0);
        close_frame();
        check("t3_locked", 48'(locked), 48'h1);
        check("t3_no_output", 48'((valid_seen - v0) + (err_seen - e0)), 48'h0);
        exp_q.push_back({24'h13579B, 24'h2468AC});
        send_pair(24'h13579B, 24'h2468AC);
        close_frame();
        check("t3_valids", 48'(valid_seen - v0), 48'h1);
        check("t3_errs", 48'(err_seen - e0), 48'h0);
        check("t3_l_data", 48'(l_data), 48'h13579B);
        check("t3_r_data", 48'(r_data), 48'h2468AC);

        // reset asserted mid left slot after a good pair
        v0 = valid_seen; e0 = err_seen;
        fork
            send_slot(1'b0, 24'hCAFE00, 32);
            begin
                #(10 * 2 * half_ns);
                reset_btn = 1'b1;
                #1;
                check("t6_async_l_data", 48'(l_data), 48'h0);
                check("t6_async_r_data", 48'(r_data), 48'h0);
                check("t6_async_locked", 48'(locked), 48'h0);
            end
        join
        @(negedge clk_100mhz);
        reset_btn = 1'b0;
        send_slot(1'b1, 24'hF00D00, 32);
        close_frame();
        check("t6_relock", 48'(locked), 48'h1);
        check("t6_no_output", 48'((valid_seen - v0) + (err_seen - e0)), 48'h0);
        exp_q.push_back({24'hC0FFEE, 24'h0BADF0});
        send_pair(24'hC0FFEE, 24'h0BADF0);
        close_frame();
        check("t6_valids", 48'(valid_seen - v0), 48'h1);
        check("t6_l_data", 48'(l_data), 48'hC0FFEE);
        check("t6_r_data", 48'(r_data), 48'h0BADF0);

        check("exp_q_drained", 48'(exp_q.size()), 48'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
